ext_mem_loader: RTL and testbench

//  Host-side initiator for the CPU's external memory ports (instruction memory *_ext, data memory *_ext_2).

---
 rtl/ext_mem_loader.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ext_mem_loader.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_loader.sv
// ext_mem_loader
// Host-side initiator for the CPU's external memory ports. Host commands arrive
// over a valid/ready stream and become single-word writes/reads on the
// instruction memory (*_ext) or data memory (*_ext_2), or a bounded window of
// cpu_enable. Read data and RUN status return over a valid/ready response stream.
//
// Ports
//   clk, arst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_op                      000 WR_I, 001 WR_D, 010 RD_I, 011 RD_D, 100 RUN, else illegal
//   cmd_addr, cmd_wdata         target address; write data or RUN cycle count
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_err           read data / elapsed cycles / 0, illegal-op flag
//   busy                        FSM not idle
//   cpu_enable                  CPU run enable
//   addr_ext .. rdata_ext       instruction memory external port
//   addr_ext_2 .. rdata_ext_2   data memory external port
module ext_mem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              cpu_enable,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    localparam logic [2:0] OP_WR_I = 3'b000;
    localparam logic [2:0] OP_WR_D = 3'b001;
    localparam logic [2:0] OP_RD_I = 3'b010;
    localparam logic [2:0] OP_RD_D = 3'b011;
    localparam logic [2:0] OP_RUN  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP,
        S_RUN
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        wen_reg, wen_next;
    logic [1:0]        ren_reg, ren_next;
    logic              port_sel_reg, port_sel_next;
    logic [2:0]        lat_cnt_reg, lat_cnt_next;
    logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              cpu_enable_reg, cpu_enable_next;

    // Per-port load strobes for the address / write-data registers.
    logic [1:0]        load_addr;
    logic [1:0]        load_wdata;

    // cmd_op[0] selects the port for all memory ops: 0 = imem, 1 = dmem.
    logic              cmd_port;
    logic [CNT_W-1:0]  run_n;
    logic [DATA_W-1:0] rdata_sel;

    logic [ADDR_W-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_wdata [2];
    logic [DATA_W-1:0] port_rdata [2];

    assign cmd_port      = cmd_op[0];
    assign run_n         = CNT_W'(cmd_wdata);
    assign port_rdata[0] = rdata_ext;
    assign port_rdata[1] = rdata_ext_2;
    assign rdata_sel     = port_rdata[port_sel_reg];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg      <= S_IDLE;
            wen_reg        <= '0;
            ren_reg        <= '0;
            port_sel_reg   <= 1'b0;
            lat_cnt_reg    <= '0;
            run_cnt_reg    <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            cpu_enable_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wen_reg        <= wen_next;
            ren_reg        <= ren_next;
            port_sel_reg   <= port_sel_next;
            lat_cnt_reg    <= lat_cnt_next;
            run_cnt_reg    <= run_cnt_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            cpu_enable_reg <= cpu_enable_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control. Strobes and cpu_enable default to 0
    // so each is high only in the cycle explicitly requested below.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        wen_next        = '0;
        ren_next        = '0;
        port_sel_next   = port_sel_reg;
        lat_cnt_next    = lat_cnt_reg;
        run_cnt_next    = run_cnt_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;
        cpu_enable_next = 1'b0;
        load_addr       = '0;
        load_wdata      = '0;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WR_I, OP_WR_D: begin
                            state_next           = S_WRITE;
                            wen_next[cmd_port]   = 1'b1;
                            load_addr[cmd_port]  = 1'b1;
                            load_wdata[cmd_port] = 1'b1;
                        end
                        OP_RD_I, OP_RD_D: begin
                            state_next          = S_RD_REQ;
                            ren_next[cmd_port]  = 1'b1;
                            load_addr[cmd_port] = 1'b1;
                            port_sel_next       = cmd_port;
                        end
                        OP_RUN: begin
                            // The elapsed count equals N, so the response word
                            // can be loaded at acceptance.
                            rsp_data_next = DATA_W'(run_n);
                            rsp_err_next  = 1'b0;
                            if (run_n == '0) begin
                                state_next = S_RESP;
                            end else begin
                                state_next      = S_RUN;
                                cpu_enable_next = 1'b1;
                                run_cnt_next    = run_n;
                            end
                        end
                        default: begin
                            state_next    = S_RESP;
                            rsp_data_next = '0;
                            rsp_err_next  = 1'b1;
                        end
                    endcase
                end
            end

            S_WRITE: begin
                state_next = S_IDLE;
            end

            S_RD_REQ: begin
                state_next   = S_RD_WAIT;
                lat_cnt_next = 3'(RD_LAT - 1);
            end

            // RD_WAIT covers the RD_LAT-1 latency cycles plus the cycle in
            // which rdata is valid; the capture happens at the end of that
            // last cycle, i.e. RD_LAT cycles after the ren cycle.
            S_RD_WAIT: begin
                if (lat_cnt_reg == 3'd0) begin
                    state_next    = S_RESP;
                    rsp_data_next = rdata_sel;
                    rsp_err_next  = 1'b0;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 3'd1;
                end
            end

            // run_cnt_reg holds the enable cycles remaining, including the
            // current one.
            S_RUN: begin
                if (run_cnt_reg == CNT_W'(1)) begin
                    state_next   = S_RESP;
                    run_cnt_next = '0;
                end else begin
                    cpu_enable_next = 1'b1;
                    run_cnt_next    = run_cnt_reg - CNT_W'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_next    = S_IDLE;
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-port address / write-data registers. A port's registers only load
    // when that port is targeted, so the idle port keeps its last values.
    // Write data loads on writes only.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_port
            logic [ADDR_W-1:0] addr_reg;
            logic [DATA_W-1:0] wdata_reg;

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    addr_reg  <= '0;
                    wdata_reg <= '0;
                end else begin
                    if (load_addr[gi]) begin
                        addr_reg <= cmd_addr;
                    end
                    if (load_wdata[gi]) begin
                        wdata_reg <= cmd_wdata;
                    end
                end
            end

            assign port_addr[gi]  = addr_reg;
            assign port_wdata[gi] = wdata_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready   = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign rsp_valid   = (state_reg == S_RESP);
    assign rsp_data    = rsp_data_reg;
    assign rsp_err     = rsp_err_reg;
    assign cpu_enable  = cpu_enable_reg;

    assign addr_ext    = port_addr[0];
    assign wdata_ext   = port_wdata[0];
    assign wen_ext     = wen_reg[0];
    assign ren_ext     = ren_reg[0];

    assign addr_ext_2  = port_addr[1];
    assign wdata_ext_2 = port_wdata[1];
    assign wen_ext_2   = wen_reg[1];
    assign ren_ext_2   = ren_reg[1];

endmodule

// File: tb/tb_ext_mem_loader.sv
`timescale 1ns/1ps
module tb_ext_mem_loader;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 32;
    localparam int RD_LAT    = 3;
    localparam int MEM_WORDS = 16;

    localparam int EV_WEN = 0;
    localparam int EV_REN = 1;
    localparam int EV_RUN = 2;
    localparam int EV_RSP = 3;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } ev_t;

    logic              clk;
    logic              arst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              cpu_enable;
    logic [ADDR_W-1:0] addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [DATA_W-1:0] rdata_ext;
    logic [ADDR_W-1:0] addr_ext_2;
    logic              wen_ext_2;
    logic              ren_ext_2;
    logic [DATA_W-1:0] wdata_ext_2;
    logic [DATA_W-1:0] rdata_ext_2;

    ext_mem_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2)
    );

    // ------------------------------------------------------------------
    // Clock, cycle counter, watchdog
    // ------------------------------------------------------------------
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // External SRAM models: read data is valid for exactly one cycle,
    // RD_LAT cycles after the ren cycle; any other time it shows junk.
    // ------------------------------------------------------------------
    logic [31:0]       imem_m [MEM_WORDS];
    logic [31:0]       dmem_m [MEM_WORDS];
    logic [RD_LAT-1:0] ivld, dvld;
    logic [31:0]       ipipe [RD_LAT];
    logic [31:0]       dpipe [RD_LAT];

    always @(posedge clk) begin
        if (wen_ext)   imem_m[addr_ext[5:2]]   <= wdata_ext;
        if (wen_ext_2) dmem_m[addr_ext_2[5:2]] <= wdata_ext_2;
        ivld[0]  <= ren_ext;
        dvld[0]  <= ren_ext_2;
        ipipe[0] <= imem_m[addr_ext[5:2]];
        dpipe[0] <= dmem_m[addr_ext_2[5:2]];
        for (int i = 1; i < RD_LAT; i++) begin
            ivld[i]  <= ivld[i-1];
            dvld[i]  <= dvld[i-1];
            ipipe[i] <= ipipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
    end

    assign rdata_ext   = (ivld[RD_LAT-1] === 1'b1) ? ipipe[RD_LAT-1] : 32'hBAD0_0BAD;
    assign rdata_ext_2 = (dvld[RD_LAT-1] === 1'b1) ? dpipe[RD_LAT-1] : 32'hBAD1_1BAD;

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int  chk_cnt  = 0;
    int  pass_cnt = 0;
    int  viol     = 0;
    int  en_rise_cyc = -1;
    int  bp_mode  = 0;   // 0 always ready, 1 random, 2 held low
    ev_t exp_q [$];

    logic [31:0] ref_imem [MEM_WORDS];
    logic [31:0] ref_dmem [MEM_WORDS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic ev_t mk_ev(input int k, input int p, input logic [31:0] a,
                                  input logic [31:0] d, input logic e);
        ev_t r;
        r.kind = k;
        r.port = p;
        r.addr = a;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    // Response back-pressure
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom % 3) != 0;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops expected events as the DUT presents them
    // ------------------------------------------------------------------
    initial begin
        int          run_len;
        int          nstb;
        logic        hold;
        logic [31:0] hold_data;
        logic        hold_err;
        ev_t         e;
        int          a_kind, a_port;
        logic [31:0] a_addr, a_data;
        run_len = 0;
        hold    = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                run_len = 0;
                hold    = 1'b0;
                continue;
            end
            nstb = int'(wen_ext) + int'(ren_ext) + int'(wen_ext_2) + int'(ren_ext_2);
            if (nstb > 1 || (cpu_enable && nstb > 0)) viol++;

            if (hold) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                check("rsp_hold_data", 64'(rsp_data), 64'(hold_data));
                check("rsp_hold_err", 64'(rsp_err), 64'(hold_err));
            end
            hold      = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
            hold_err  = rsp_err;

            if (cpu_enable) begin
                if (run_len == 0) en_rise_cyc = cyc;
                run_len++;
            end else if (run_len > 0) begin
                check("event_expected_run", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("run_kind", 64'(EV_RUN), 64'(e.kind));
                    check("run_len", 64'(run_len), 64'(e.data));
                end
                run_len = 0;
            end

            if (nstb > 0) begin
                a_kind = (wen_ext || wen_ext_2) ? EV_WEN : EV_REN;
                a_port = (wen_ext_2 || ren_ext_2) ? 1 : 0;
                a_addr = (a_port == 1) ? addr_ext_2 : addr_ext;
                a_data = (a_port == 1) ? wdata_ext_2 : wdata_ext;
                check("event_expected_strobe", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 64'(a_kind), 64'(e.kind));
                    check("strobe_port", 64'(a_port), 64'(e.port));
                    check("strobe_addr", 64'(a_addr), 64'(e.addr));
                    if (e.kind == EV_WEN) check("strobe_wdata", 64'(a_data), 64'(e.data));
                end
            end

            if (rsp_valid && rsp_ready) begin
                check("event_expected_rsp", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_kind", 64'(EV_RSP), 64'(e.kind));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic send(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, output int acc);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = data;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else n++;
        end
        check("cmd_accept", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        acc       = cyc;
        cmd_valid = 1'b0;
        $display("cmd op=%0d addr=0x%08h data=0x%08h accepted_cycle=%0d", op, addr, data, acc);
    endtask

    // Reference model: compute the expected events of one command.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, output int acc);
        int w;
        w = int'(addr[5:2]);
        case (op)
            3'd0: begin
                ref_imem[w] = data;
                exp_q.push_back(mk_ev(EV_WEN, 0, addr, data, 1'b0));
            end
            3'd1: begin
                ref_dmem[w] = data;
                exp_q.push_back(mk_ev(EV_WEN, 1, addr, data, 1'b0));
            end
            3'd2: begin
                exp_q.push_back(mk_ev(EV_REN, 0, addr, 32'd0, 1'b0));
                exp_q.push_back(mk_ev(EV_RSP, 0, 32'd0, ref_imem[w], 1'b0));
            end
            3'd3: begin
                exp_q.push_back(mk_ev(EV_REN, 1, addr, 32'd0, 1'b0));
                exp_q.push_back(mk_ev(EV_RSP, 0, 32'd0, ref_dmem[w], 1'b0));
            end
            3'd4: begin
                if (data != 32'd0) exp_q.push_back(mk_ev(EV_RUN, 0, 32'd0, data, 1'b0));
                exp_q.push_back(mk_ev(EV_RSP, 0, 32'd0, data, 1'b0));
            end
            default: begin
                exp_q.push_back(mk_ev(EV_RSP, 0, 32'd0, 32'd0, 1'b1));
            end
        endcase
        send(op, addr, data, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_events", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int acc;
        int accs [4];
        int n;
        int sel;
        arst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'd0);
        check("reset_enable", 64'(cpu_enable), 64'd0);
        check("reset_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        check("reset_addr", {addr_ext, addr_ext_2}, 64'd0);
        check("reset_wdata", {wdata_ext, wdata_ext_2}, 64'd0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload both memories so every later read has a known value.
        for (int i = 0; i < MEM_WORDS; i++) begin
            issue(3'd0, 32'(i) << 2, $urandom, acc);
            issue(3'd1, 32'(i) << 2, $urandom, acc);
        end
        drain();

        // Write then read the instruction memory.
        issue(3'd0, 32'h4, 32'h2008_0005, acc);
        issue(3'd2, 32'h4, 32'd0, acc);
        drain();

        // Data memory read with response stalled for 5 cycles.
        issue(3'd1, 32'h10, 32'hDEAD_BEEF, acc);
        bp_mode = 2;
        issue(3'd3, 32'h10, 32'd0, acc);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_d_rsp_seen", 64'(rsp_valid), 64'd1);
        repeat (5) @(negedge clk);
        bp_mode = 0;
        drain();
        check("cmd_ready_after_retire", 64'(cmd_ready), 64'd1);
        check("rsp_valid_after_retire", 64'(rsp_valid), 64'd0);

        // RUN window of 20 cycles, then an empty RUN.
        issue(3'd4, 32'd0, 32'd20, acc);
        drain();
        check("run_start_cycle", 64'(en_rise_cyc), 64'(acc));
        issue(3'd4, 32'd0, 32'd0, acc);
        drain();

        // Illegal opcodes.
        issue(3'b111, 32'h8, 32'h1234_5678, acc);
        issue(3'b101, 32'h8, 32'h1234_5678, acc);
        issue(3'b110, 32'h8, 32'h1234_5678, acc);
        drain();

        // Back-to-back writes: one accept every two cycles, then read one back.
        for (int i = 0; i < 4; i++) issue(3'd0, 32'(i + 8) << 2, $urandom, accs[i]);
        for (int i = 1; i < 4; i++) check("wr_throughput", 64'(accs[i] - accs[i-1]), 64'd2);
        issue(3'd2, 32'(10) << 2, 32'd0, acc);
        drain();

        // Randomised mix with random back-pressure.
        bp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 11));
            if (sel < 3)       issue(3'(sel & 1), rnd_addr(), $urandom, acc);
            else if (sel < 8)  issue(3'(2 + (sel & 1)), rnd_addr(), $urandom, acc);
            else if (sel < 10) issue(3'd4, 32'd0, 32'($urandom_range(0, 12)), acc);
            else               issue(3'(5 + (sel - 10) * 2), rnd_addr(), $urandom, acc);
        end
        drain();
        bp_mode = 0;

        // Reset in the 7th cycle of a 20-cycle RUN.
        issue(3'd4, 32'd0, 32'd20, acc);
        n = 0;
        while (cyc < acc + 6 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #3;
        arst_n = 1'b0;
        #1;
        check("midrun_enable_off", 64'(cpu_enable), 64'd0);
        check("midrun_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'd0);
        check("midrun_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        check("midrun_addr", {addr_ext, addr_ext_2}, 64'd0);
        check("midrun_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        issue(3'd3, 32'h10, 32'd0, acc);
        issue(3'd2, 32'h4, 32'd0, acc);
        drain();

        check("strobe_exclusive", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
